// File: rtl/adcc_timing_pkg.sv
// Shared timing constants, FSM encodings and the statistics record layout
// for the SynchrM->LaunchM delay path.
package adcc_timing_pkg;

    localparam int                 TIMER_W      = 7;
    localparam logic [TIMER_W-1:0] TIMEOUT_CODE = 7'h7F;

    // Sized for the largest window (2^8 samples) so the record type is parameter-free.
    localparam int                 TMO_MAX_W    = 9;

    localparam logic [0:0]         ST_ARM       = 1'b0;
    localparam logic [0:0]         ST_ACCUM     = 1'b1;

    typedef struct packed {
        logic [TIMER_W-1:0]   avg;
        logic [TIMER_W-1:0]   min;
        logic [TIMER_W-1:0]   max;
        logic [TMO_MAX_W-1:0] timeouts;
        logic                 overrun;
    } stat_rec_t;

    function automatic logic out_of_window(input logic [TIMER_W-1:0] x,
                                           input logic [TIMER_W-1:0] lo,
                                           input logic [TIMER_W-1:0] hi);
        return (x < lo) || (x > hi);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous strobe followed by a registered
// single-cycle pulse on its rising edge.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pulse <= r_sync2 & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/launch_delay_monitor.sv
// Windowed statistics over the SynchrM->LaunchM delay samples, with per-sample
// range flagging and a sticky alarm for consecutive lost launches.
module launch_delay_monitor
    import adcc_timing_pkg::*;
#(
    parameter int AVG_LOG2   = 2,
    parameter int MISS_LIMIT = 4
) (
    input  logic               Clk100MHz,
    input  logic               Rst,
    input  logic               SynchrM,
    input  logic [7:0]         ResultTimer,
    input  logic [TIMER_W-1:0] LoLimit,
    input  logic [TIMER_W-1:0] HiLimit,
    input  logic               StatReady,
    output logic               StatValid,
    output logic [TIMER_W-1:0] StatAvg,
    output logic [TIMER_W-1:0] StatMin,
    output logic [TIMER_W-1:0] StatMax,
    output logic [AVG_LOG2:0]  StatTimeouts,
    output logic               StatOverrun,
    output logic               OutOfWindow,
    output logic               LaunchLost
);

    localparam int SUM_W = TIMER_W + AVG_LOG2;
    localparam int TMO_W = AVG_LOG2 + 1;

    logic                r_state;
    logic [TIMER_W-1:0]  r_x;
    logic                r_xStb;
    logic [SUM_W-1:0]    r_sum;
    logic [TIMER_W-1:0]  r_min;
    logic [TIMER_W-1:0]  r_max;
    logic [TMO_W-1:0]    r_tmo;
    logic [AVG_LOG2-1:0] r_cnt;
    stat_rec_t           r_rec;
    logic                r_valid;
    logic                r_oow;
    logic [7:0]          r_missCnt;
    logic                r_lost;

    logic                w_pulse;
    logic                w_isTmo;
    logic                w_doAccum;
    logic                w_lastSample;
    logic                w_load;
    logic                w_accept;
    logic [SUM_W-1:0]    w_sumNext;
    logic [TIMER_W-1:0]  w_minNext;
    logic [TIMER_W-1:0]  w_maxNext;
    logic [TMO_W-1:0]    w_tmoNext;
    logic [7:0]          w_missNext;
    logic [TMO_MAX_W:0]  w_unusedBits;

    sync_edge_det u_synchrEdge (
        .i_clk   (Clk100MHz),
        .i_rst   (Rst),
        .i_async (SynchrM),
        .o_pulse (w_pulse)
    );

    assign w_isTmo      = (r_x == TIMEOUT_CODE);
    assign w_doAccum    = r_xStb && (r_state == ST_ACCUM);
    assign w_lastSample = (r_cnt == '1);
    assign w_load       = w_doAccum && w_lastSample;
    assign w_accept     = r_valid && StatReady;
    assign w_sumNext    = r_sum + SUM_W'(r_x);
    assign w_minNext    = (r_x < r_min) ? r_x : r_min;
    assign w_maxNext    = (r_x > r_max) ? r_x : r_max;
    assign w_tmoNext    = r_tmo + TMO_W'(w_isTmo);
    assign w_missNext   = (r_missCnt == 8'hFF) ? r_missCnt : r_missCnt + 8'd1;

    always_ff @(posedge Clk100MHz) begin
        if (Rst) begin
            r_state   <= ST_ARM;
            r_x       <= '0;
            r_xStb    <= 1'b0;
            r_sum     <= '0;
            r_min     <= TIMEOUT_CODE;
            r_max     <= '0;
            r_tmo     <= '0;
            r_cnt     <= '0;
            r_oow     <= 1'b0;
            r_missCnt <= '0;
            r_lost    <= 1'b0;
        end else begin
            r_xStb <= w_pulse;
            if (w_pulse) begin
                r_x <= ResultTimer[TIMER_W-1:0];
            end

            // The first sample after reset refers to a stale timer result.
            if (r_xStb && (r_state == ST_ARM)) begin
                r_state <= ST_ACCUM;
            end

            r_oow <= w_doAccum && out_of_window(r_x, LoLimit, HiLimit);

            if (w_doAccum) begin
                r_cnt <= r_cnt + AVG_LOG2'(1);
                if (w_lastSample) begin
                    r_sum <= '0;
                    r_min <= TIMEOUT_CODE;
                    r_max <= '0;
                    r_tmo <= '0;
                end else begin
                    r_sum <= w_sumNext;
                    r_min <= w_minNext;
                    r_max <= w_maxNext;
                    r_tmo <= w_tmoNext;
                end

                if (w_isTmo) begin
                    r_missCnt <= w_missNext;
                    if (w_missNext >= 8'(MISS_LIMIT)) begin
                        r_lost <= 1'b1;
                    end
                end else begin
                    r_missCnt <= '0;
                end
            end
        end
    end

    // A fresh record always wins over an accept in the same cycle.
    always_ff @(posedge Clk100MHz) begin
        if (Rst) begin
            r_rec   <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_rec.avg      <= TIMER_W'(w_sumNext >> AVG_LOG2);
            r_rec.min      <= w_minNext;
            r_rec.max      <= w_maxNext;
            r_rec.timeouts <= TMO_MAX_W'(w_tmoNext);
            r_rec.overrun  <= r_valid && !StatReady;
            r_valid        <= 1'b1;
        end else if (w_accept) begin
            r_rec.overrun <= 1'b0;
            r_valid       <= 1'b0;
        end
    end

    assign StatValid    = r_valid;
    assign StatAvg      = r_rec.avg;
    assign StatMin      = r_rec.min;
    assign StatMax      = r_rec.max;
    assign StatTimeouts = r_rec.timeouts[TMO_W-1:0];
    assign StatOverrun  = r_rec.overrun;
    assign OutOfWindow  = r_oow;
    assign LaunchLost   = r_lost;

    assign w_unusedBits = {ResultTimer[7], r_rec.timeouts};

endmodule

// File: tb/tb_launch_delay_monitor.sv
// Self-checking bench for launch_delay_monitor: directed scenarios plus random
// samples, checked against a window/handshake model built from queues.
module tb_launch_delay_monitor;

    localparam int AVG_LOG2   = 2;
    localparam int MISS_LIMIT = 4;
    localparam int WIN        = 1 << AVG_LOG2;

    logic              clk100MHz;
    logic              rst;
    logic              synchrM;
    logic [7:0]        resultTimer;
    logic [6:0]        loLimit;
    logic [6:0]        hiLimit;
    logic              statReady;
    logic              statValid;
    logic [6:0]        statAvg;
    logic [6:0]        statMin;
    logic [6:0]        statMax;
    logic [AVG_LOG2:0] statTimeouts;
    logic              statOverrun;
    logic              outOfWindow;
    logic              launchLost;

    int checkCount = 0;
    int failCount  = 0;

    int winQ[$];
    bit expDiscard;
    bit expValid;
    bit expOverrun;
    bit expLost;
    int expAvg, expMin, expMax, expTmo;
    int missRun;

    launch_delay_monitor #(
        .AVG_LOG2   (AVG_LOG2),
        .MISS_LIMIT (MISS_LIMIT)
    ) dut (
        .Clk100MHz    (clk100MHz),
        .Rst          (rst),
        .SynchrM      (synchrM),
        .ResultTimer  (resultTimer),
        .LoLimit      (loLimit),
        .HiLimit      (hiLimit),
        .StatReady    (statReady),
        .StatValid    (statValid),
        .StatAvg      (statAvg),
        .StatMin      (statMin),
        .StatMax      (statMax),
        .StatTimeouts (statTimeouts),
        .StatOverrun  (statOverrun),
        .OutOfWindow  (outOfWindow),
        .LaunchLost   (launchLost)
    );

    initial begin
        clk100MHz = 1'b0;
        forever #5 clk100MHz = ~clk100MHz;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkRecord(input string tag);
        checkOutput({tag, ".valid"},   statValid,    expValid);
        checkOutput({tag, ".avg"},     statAvg,      expAvg);
        checkOutput({tag, ".min"},     statMin,      expMin);
        checkOutput({tag, ".max"},     statMax,      expMax);
        checkOutput({tag, ".tmo"},     statTimeouts, expTmo);
        checkOutput({tag, ".overrun"}, statOverrun,  expOverrun);
        checkOutput({tag, ".lost"},    launchLost,   expLost);
    endtask

    // Reference model for one strobe, evaluated at the clock where its effects appear.
    task automatic modelSample(input int x, input bit readyNow, output bit oow);
        bit load;
        int sum, mn, mx, tmo;
        load = 1'b0;
        oow  = 1'b0;
        if (expDiscard) begin
            expDiscard = 1'b0;
        end else begin
            oow = (x < int'(loLimit)) || (x > int'(hiLimit));
            if (x == 127) begin
                if (missRun < 255) missRun++;
            end else begin
                missRun = 0;
            end
            if (missRun >= MISS_LIMIT) expLost = 1'b1;
            winQ.push_back(x);
            if (winQ.size() == WIN) begin
                sum = 0; mn = 127; mx = 0; tmo = 0;
                foreach (winQ[i]) begin
                    sum += winQ[i];
                    if (winQ[i] < mn) mn = winQ[i];
                    if (winQ[i] > mx) mx = winQ[i];
                    if (winQ[i] == 127) tmo++;
                end
                expAvg = sum / WIN;
                expMin = mn;
                expMax = mx;
                expTmo = tmo;
                winQ.delete();
                load = 1'b1;
            end
        end
        if (load) begin
            expOverrun = expValid && !readyNow;
            expValid   = 1'b1;
        end else if (expValid && readyNow) begin
            expValid   = 1'b0;
            expOverrun = 1'b0;
        end
    endtask

    task automatic doReset();
        @(negedge clk100MHz);
        rst = 1'b1;
        repeat (2) @(posedge clk100MHz);
        #1;
        winQ.delete();
        expDiscard = 1'b1;
        expValid   = 1'b0;
        expOverrun = 1'b0;
        expLost    = 1'b0;
        expAvg = 0; expMin = 0; expMax = 0; expTmo = 0;
        missRun = 0;
        checkRecord("reset");
        checkOutput("reset.oow", outOfWindow, 0);
        @(negedge clk100MHz);
        rst = 1'b0;
    endtask

    // One SynchrM strobe; readyPulse raises StatReady for exactly the clock where the sample lands.
    task automatic applyStimulus(input logic [6:0] value, input bit readyPulse);
        bit expOow;
        logic topBit;
        topBit = 1'($urandom_range(0, 1));
        @(negedge clk100MHz);
        resultTimer = {topBit, value};
        synchrM     = 1'b1;
        @(posedge clk100MHz);
        repeat (3) @(posedge clk100MHz);
        #1;
        checkOutput("oowEarly", outOfWindow, 0);
        if (readyPulse) begin
            @(negedge clk100MHz);
            statReady = 1'b1;
        end
        @(posedge clk100MHz);
        #1;
        modelSample(int'(value), readyPulse, expOow);
        checkOutput("oow", outOfWindow, expOow);
        checkRecord("rec");
        if (readyPulse) begin
            @(negedge clk100MHz);
            statReady = 1'b0;
        end
        @(posedge clk100MHz);
        #1;
        checkOutput("oowWidth", outOfWindow, 0);
        @(negedge clk100MHz);
        synchrM = 1'b0;
        repeat (6) @(negedge clk100MHz);
    endtask

    task automatic acceptRecord();
        @(negedge clk100MHz);
        statReady = 1'b1;
        @(posedge clk100MHz);
        #1;
        if (expValid) begin
            expValid   = 1'b0;
            expOverrun = 1'b0;
        end
        checkOutput("accept.valid", statValid, expValid);
        checkOutput("accept.overrun", statOverrun, expOverrun);
        @(negedge clk100MHz);
        statReady = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        synchrM     = 1'b0;
        resultTimer = 8'h00;
        loLimit     = 7'd5;
        hiLimit     = 7'd100;
        statReady   = 1'b0;

        doReset();

        // Basic window after the discarded first sample
        applyStimulus(7'($urandom_range(0, 127)), 1'b0);
        applyStimulus(7'd10, 1'b0);
        applyStimulus(7'd20, 1'b0);
        applyStimulus(7'd30, 1'b0);
        applyStimulus(7'd40, 1'b0);
        checkOutput("t1.avg", statAvg, 25);
        checkOutput("t1.min", statMin, 10);
        checkOutput("t1.max", statMax, 40);
        acceptRecord();

        // Out-of-range samples including a timeout
        applyStimulus(7'd3, 1'b0);
        applyStimulus(7'd127, 1'b0);
        applyStimulus(7'd50, 1'b0);
        applyStimulus(7'd101, 1'b0);
        checkOutput("t2.avg", statAvg, 70);
        checkOutput("t2.tmo", statTimeouts, 1);
        acceptRecord();

        // Two windows without acceptance, then the next record is clean
        for (int i = 0; i < 2 * WIN; i++) applyStimulus(7'($urandom_range(0, 126)), 1'b0);
        checkOutput("t3.overrun", statOverrun, 1);
        acceptRecord();
        for (int i = 0; i < WIN; i++) applyStimulus(7'($urandom_range(0, 126)), 1'b0);
        checkOutput("t3.clean", statOverrun, 0);

        // Load and accept in the same clock
        for (int i = 0; i < WIN - 1; i++) applyStimulus(7'($urandom_range(0, 126)), 1'b0);
        applyStimulus(7'd64, 1'b1);
        acceptRecord();

        // Consecutive timeouts raise the sticky alarm
        doReset();
        applyStimulus(7'd127, 1'b0);
        applyStimulus(7'd127, 1'b0);
        applyStimulus(7'd127, 1'b0);
        applyStimulus(7'd127, 1'b0);
        applyStimulus(7'd9, 1'b0);
        applyStimulus(7'd127, 1'b0);
        applyStimulus(7'd127, 1'b0);
        applyStimulus(7'd127, 1'b0);
        checkOutput("t4.notYet", launchLost, 0);
        applyStimulus(7'd127, 1'b0);
        checkOutput("t4.lost", launchLost, 1);
        applyStimulus(7'd20, 1'b0);
        applyStimulus(7'd30, 1'b1);

        // Reset mid-window drops partial and pending state
        applyStimulus(7'd11, 1'b0);
        applyStimulus(7'd12, 1'b0);
        doReset();
        applyStimulus(7'd90, 1'b0);
        for (int i = 0; i < WIN; i++) applyStimulus(7'(40 + i), 1'b0);
        acceptRecord();

        // Inverted limits flag every sample
        loLimit = 7'd60;
        hiLimit = 7'd20;
        for (int i = 0; i < WIN; i++) applyStimulus(7'($urandom_range(0, 127)), 1'b0);
        acceptRecord();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            logic [6:0] v;
            if ($urandom_range(0, 9) < 2) v = 7'd127;
            else                          v = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) begin
                loLimit = 7'($urandom_range(0, 127));
                hiLimit = 7'($urandom_range(0, 127));
            end
            applyStimulus(v, 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 5) == 0) acceptRecord();
        end

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
        $finish;
    end

endmodule
